// File: rtl/bcm_pkg.sv
// Shared definitions for the bunch-current-monitor readout sequencer.
//   - Buffer geometry (channels, samples per row, row address width)
//   - Index widths and bit offsets of the fields inside the address word
//   - Control-register and status-register bit positions
//   - Sequencer FSM state encoding and the address-word packing helper
package bcm_pkg;

    localparam int unsigned CHANNEL_COUNT         = 2;
    localparam int unsigned AXI_SAMPLES_PER_CLOCK = 4;
    localparam int unsigned SAMPLE_CAPACITY       = 4096;

    localparam int unsigned DPRAM_ADDRESS_WIDTH =
        $clog2(SAMPLE_CAPACITY / AXI_SAMPLES_PER_CLOCK);
    localparam int unsigned SAMPLE_INDEX_WIDTH =
        (AXI_SAMPLES_PER_CLOCK > 1) ? $clog2(AXI_SAMPLES_PER_CLOCK) : 1;
    localparam int unsigned CHANNEL_INDEX_WIDTH =
        (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1;

    // Field offsets inside seqAddrData
    localparam int unsigned ADDR_SAMPLE_LSB  = 0;
    localparam int unsigned ADDR_ROW_LSB     = SAMPLE_INDEX_WIDTH;
    localparam int unsigned ADDR_CHANNEL_LSB = 24;

    // Control register (GPIO_OUT) bits
    localparam int unsigned CTL_START_BIT = 31;
    localparam int unsigned CTL_ABORT_BIT = 30;
    localparam int unsigned CTL_AUTO_BIT  = 29;

    // Acquisition status bit: acquisition in progress
    localparam int unsigned ACQ_ACTIVE_BIT = 31;

    localparam int unsigned WORD_COUNT_WIDTH = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_PUSH
    } seq_state_e;

    function automatic logic [31:0] addr_word(
        input logic [SAMPLE_INDEX_WIDTH-1:0]  sample,
        input logic [CHANNEL_INDEX_WIDTH-1:0] channel,
        input logic [DPRAM_ADDRESS_WIDTH-1:0] row
    );
        logic [31:0] w;
        w = '0;
        w[ADDR_SAMPLE_LSB  +: SAMPLE_INDEX_WIDTH]  = sample;
        w[ADDR_ROW_LSB     +: DPRAM_ADDRESS_WIDTH] = row;
        w[ADDR_CHANNEL_LSB +: CHANNEL_INDEX_WIDTH] = channel;
        return w;
    endfunction

endpackage

// File: rtl/bcm_index_counter.sv
// Nested sample/channel/row counter for the readout walk.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   clear_i          : return all indices to zero (wins over advance_i)
//   advance_i        : step to the next word (sample fastest, then channel, then row)
//   row_last_i       : last row of the current buffer
//   sample_o, channel_o, row_o : current indices
//   last_o           : current indices address the final word of the buffer
module bcm_index_counter
    import bcm_pkg::*;
(
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    input  logic                           advance_i,
    input  logic [DPRAM_ADDRESS_WIDTH-1:0] row_last_i,
    output logic [SAMPLE_INDEX_WIDTH-1:0]  sample_o,
    output logic [CHANNEL_INDEX_WIDTH-1:0] channel_o,
    output logic [DPRAM_ADDRESS_WIDTH-1:0] row_o,
    output logic                           last_o
);

    localparam logic [SAMPLE_INDEX_WIDTH-1:0] SAMPLE_MAX =
        SAMPLE_INDEX_WIDTH'(AXI_SAMPLES_PER_CLOCK - 1);
    localparam logic [CHANNEL_INDEX_WIDTH-1:0] CHANNEL_MAX =
        CHANNEL_INDEX_WIDTH'(CHANNEL_COUNT - 1);

    logic [SAMPLE_INDEX_WIDTH-1:0]  sample_q,  sample_d;
    logic [CHANNEL_INDEX_WIDTH-1:0] channel_q, channel_d;
    logic [DPRAM_ADDRESS_WIDTH-1:0] row_q,     row_d;

    always_comb begin
        sample_d  = sample_q;
        channel_d = channel_q;
        row_d     = row_q;
        if (clear_i) begin
            sample_d  = '0;
            channel_d = '0;
            row_d     = '0;
        end else if (advance_i) begin
            if (sample_q != SAMPLE_MAX) begin
                sample_d = sample_q + SAMPLE_INDEX_WIDTH'(1);
            end else begin
                sample_d = '0;
                if (channel_q != CHANNEL_MAX) begin
                    channel_d = channel_q + CHANNEL_INDEX_WIDTH'(1);
                end else begin
                    channel_d = '0;
                    // Never advanced past last_o, so the row cannot wrap mid-buffer
                    row_d     = row_q + DPRAM_ADDRESS_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q  <= '0;
            channel_q <= '0;
            row_q     <= '0;
        end else begin
            sample_q  <= sample_d;
            channel_q <= channel_d;
            row_q     <= row_d;
        end
    end

    assign sample_o  = sample_q;
    assign channel_o = channel_q;
    assign row_o     = row_q;
    assign last_o    = (sample_q == SAMPLE_MAX) && (channel_q == CHANNEL_MAX) &&
                       (row_q == row_last_i);

endmodule

// File: rtl/bcm_readout_sequencer.sv
// Hardware reader for the bunch-current-monitor acquisition buffer.
// Walks every row/channel/sample of the accumulation DPRAM, strobing each
// address, waiting for the cross-domain read path, and streaming the readout.
//   sysClk, sysReset            : system clock, synchronous active-high reset
//   sysCsrStrobe, GPIO_OUT      : control write (start/abort/auto bits)
//   acqStatus                   : [31] acquisition active, low bits = last row
//   acqReadout                  : readout register from the acquisition block
//   seqAddrStrobe, seqAddrData  : address strobe and address word
//   seqStatus                   : busy/overrun/auto/done/startRejected/word count
//   m_tdata/m_tvalid/m_tready/m_tlast : readout stream
module bcm_readout_sequencer
    import bcm_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        sysClk,
    input  logic        sysReset,
    input  logic        sysCsrStrobe,
    input  logic [31:0] GPIO_OUT,
    input  logic [31:0] acqStatus,
    input  logic [31:0] acqReadout,
    output logic        seqAddrStrobe,
    output logic [31:0] seqAddrData,
    output logic [31:0] seqStatus,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    seq_state_e                     state_q,    state_d;
    logic [SETTLE_W-1:0]            settle_q,   settle_d;
    logic [DPRAM_ADDRESS_WIDTH-1:0] row_last_q, row_last_d;
    logic [WORD_COUNT_WIDTH-1:0]    words_q,    words_d;
    logic                           auto_q,     auto_d;
    logic                           done_q,     done_d;
    logic                           overrun_q,  overrun_d;
    logic                           rejected_q, rejected_d;
    logic [31:0]                    tdata_q,    tdata_d;
    logic                           tvalid_q,   tvalid_d;
    logic                           tlast_q,    tlast_d;
    logic                           acq_prev_q;
    logic                           acq_fall_q;

    logic                           idx_clear;
    logic                           idx_advance;
    logic [SAMPLE_INDEX_WIDTH-1:0]  idx_sample;
    logic [CHANNEL_INDEX_WIDTH-1:0] idx_channel;
    logic [DPRAM_ADDRESS_WIDTH-1:0] idx_row;
    logic                           idx_last;

    logic acq_active;
    logic acq_rise;
    logic abort_req;
    logic start_req;
    logic auto_start;

    bcm_index_counter u_index (
        .clk_i      (sysClk),
        .rst_i      (sysReset),
        .clear_i    (idx_clear),
        .advance_i  (idx_advance),
        .row_last_i (row_last_q),
        .sample_o   (idx_sample),
        .channel_o  (idx_channel),
        .row_o      (idx_row),
        .last_o     (idx_last)
    );

    assign acq_active = acqStatus[ACQ_ACTIVE_BIT];
    assign acq_rise   = acq_active & ~acq_prev_q;
    assign abort_req  = sysCsrStrobe & GPIO_OUT[CTL_ABORT_BIT];
    assign start_req  = sysCsrStrobe & GPIO_OUT[CTL_START_BIT] & ~abort_req;
    // Falling edge is pipelined one cycle; re-check the live bit so a
    // back-to-back acquisition is not read while it is being written.
    assign auto_start = auto_q & acq_fall_q & ~acq_active & ~abort_req;

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        row_last_d  = row_last_q;
        words_d     = words_q;
        auto_d      = auto_q;
        done_d      = done_q;
        overrun_d   = overrun_q;
        rejected_d  = rejected_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        idx_clear   = 1'b0;
        idx_advance = 1'b0;

        if (sysCsrStrobe) begin
            auto_d = GPIO_OUT[CTL_AUTO_BIT];
        end

        // A start seen while busy or while acquiring (including the cycle
        // acquisition rises) is refused.
        if (start_req && (state_q != ST_IDLE || acq_active)) begin
            rejected_d = 1'b1;
        end

        if (state_q != ST_IDLE && (abort_req || acq_rise)) begin
            state_d  = ST_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (acq_rise) begin
                overrun_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if ((start_req && !acq_active) || auto_start) begin
                        state_d    = ST_STROBE;
                        row_last_d = acqStatus[DPRAM_ADDRESS_WIDTH-1:0];
                        idx_clear  = 1'b1;
                        words_d    = '0;
                        done_d     = 1'b0;
                        overrun_d  = 1'b0;
                        rejected_d = 1'b0;
                    end
                end
                ST_STROBE: begin
                    settle_d = SETTLE_W'(SETTLE_CYCLES - 1);
                    state_d  = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q == '0) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        settle_d = settle_q - SETTLE_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    tdata_d  = acqReadout;
                    tvalid_d = 1'b1;
                    tlast_d  = idx_last;
                    state_d  = ST_PUSH;
                end
                ST_PUSH: begin
                    if (m_tready) begin
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        words_d  = words_q + WORD_COUNT_WIDTH'(1);
                        if (tlast_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_advance = 1'b1;
                            state_d     = ST_STROBE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            row_last_q <= '0;
            words_q    <= '0;
            auto_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rejected_q <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            acq_prev_q <= 1'b0;
            acq_fall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            row_last_q <= row_last_d;
            words_q    <= words_d;
            auto_q     <= auto_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
            rejected_q <= rejected_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            acq_prev_q <= acq_active;
            acq_fall_q <= acq_prev_q & ~acq_active;
        end
    end

    assign seqAddrStrobe = (state_q == ST_STROBE);
    assign seqAddrData   = (state_q == ST_STROBE) ?
                           addr_word(idx_sample, idx_channel, idx_row) : '0;
    assign seqStatus     = {(state_q != ST_IDLE), overrun_q, auto_q, done_q,
                            rejected_q, 3'b000, words_q};
    assign m_tdata       = tdata_q;
    assign m_tvalid      = tvalid_q;
    assign m_tlast       = tlast_q;

    logic unused_inputs;
    assign unused_inputs = ^{acqStatus[30:DPRAM_ADDRESS_WIDTH], GPIO_OUT[28:0]};

endmodule

// File: tb/tb_bcm_readout_sequencer.sv
module tb_bcm_readout_sequencer;

    localparam int unsigned SETTLE = 16;
    localparam logic [31:0] START  = 32'h8000_0000;
    localparam logic [31:0] ABORT  = 32'h4000_0000;
    localparam logic [31:0] AUTO   = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        sysReset;
    logic        sysCsrStrobe;
    logic [31:0] GPIO_OUT;
    logic [31:0] acqStatus;
    logic [31:0] acqReadout;
    logic        seqAddrStrobe;
    logic [31:0] seqAddrData;
    logic [31:0] seqStatus;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned strobe_cnt = 0;
    int unsigned hs_count = 0;
    int unsigned tlast_cnt = 0;
    int unsigned rdy_mode = 1;   // 0 never ready, 1 always ready, 2 random 30%

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_word_t;

    logic [31:0] exp_addr_q[$];
    exp_word_t   exp_word_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    logic [31:0] rd_addr  = '0;
    int unsigned rd_delay = 0;

    always #5 clk = ~clk;

    bcm_readout_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .sysClk        (clk),
        .sysReset      (sysReset),
        .sysCsrStrobe  (sysCsrStrobe),
        .GPIO_OUT      (GPIO_OUT),
        .acqStatus     (acqStatus),
        .acqReadout    (acqReadout),
        .seqAddrStrobe (seqAddrStrobe),
        .seqAddrData   (seqAddrData),
        .seqStatus     (seqStatus),
        .m_tdata       (m_tdata),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast)
    );

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [31:0] d);
        sysCsrStrobe = 1'b1;
        GPIO_OUT     = d;
        tick();
        sysCsrStrobe = 1'b0;
        GPIO_OUT     = '0;
    endtask

    task automatic push_frame(input int unsigned row_last);
        logic [31:0] a;
        exp_word_t   w;
        for (int unsigned r = 0; r <= row_last; r++)
            for (int unsigned c = 0; c < 2; c++)
                for (int unsigned s = 0; s < 4; s++) begin
                    a = (32'(c) << 24) | (32'(r) << 2) | 32'(s);
                    exp_addr_q.push_back(a);
                    w.data = rd_model(a);
                    w.last = (r == row_last) && (c == 1) && (s == 3);
                    exp_word_q.push_back(w);
                end
    endtask

    task automatic flush();
        exp_addr_q.delete();
        exp_word_q.delete();
    endtask

    task automatic clear_counts();
        strobe_cnt = 0;
        hs_count   = 0;
        tlast_cnt  = 0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned budget);
        int unsigned n;
        n = 0;
        while (seqStatus[31] && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 32'd1);
    endtask

    // Acquisition-block read path: garbage right after the strobe, the
    // addressed word a few cycles later (well inside the settle window).
    always @(posedge clk) begin
        if (sysReset) begin
            acqReadout <= '0;
            rd_delay   <= 0;
        end else if (seqAddrStrobe) begin
            rd_addr    <= seqAddrData;
            rd_delay   <= 6;
            acqReadout <= 32'hDEAD_BEEF;
        end else if (rd_delay != 0) begin
            rd_delay <= rd_delay - 1;
            if (rd_delay == 1) acqReadout <= rd_model(rd_addr);
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = ($urandom_range(0, 9) < 3);
            endcase
        end
    end

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (sysReset) begin
            prev_stall = 1'b0;
        end else begin
            if (seqAddrStrobe) begin
                strobe_cnt++;
                check("strobe_in_push", 32'(m_tvalid), 32'd0);
                check("strobe_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) check("addr", seqAddrData, exp_addr_q.pop_front());
            end
            if (prev_stall && m_tvalid) begin
                check("stall_data", m_tdata, prev_data);
                check("stall_last", 32'(m_tlast), 32'(prev_last));
            end
            if (m_tvalid && m_tready) begin
                hs_count++;
                if (m_tlast) tlast_cnt++;
                check("word_expected", 32'(exp_word_q.size() != 0), 32'd1);
                if (exp_word_q.size() != 0) begin
                    exp_word_t w;
                    w = exp_word_q.pop_front();
                    check("tdata", m_tdata, w.data);
                    check("tlast", 32'(m_tlast), 32'(w.last));
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        sysReset     = 1'b1;
        sysCsrStrobe = 1'b0;
        GPIO_OUT     = '0;
        acqStatus    = '0;
        repeat (3) tick();

        // Reset state
        check("rst_status", seqStatus, 32'd0);
        check("rst_strobe", 32'(seqAddrStrobe), 32'd0);
        check("rst_addr", seqAddrData, 32'd0);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        sysReset = 1'b0;
        tick();

        // Full frame, rowLast=3, always ready
        clear_counts();
        rdy_mode  = 1;
        acqStatus = 32'h0000_0003;
        push_frame(3);
        csr_write(START);
        check("t1_first_strobe", 32'(seqAddrStrobe), 32'd1);
        check("t1_busy", 32'(seqStatus[31]), 32'd1);
        n = 0;
        while (!m_tvalid && n < 100) begin tick(); n++; end
        check("t1_latency", n, SETTLE + 2);
        n = 0;
        while (m_tvalid && n < 100) begin tick(); n++; end
        while (!m_tvalid && n < 100) begin tick(); n++; end
        check("t1_period", n, SETTLE + 3);
        wait_idle("t1", 2000);
        check("t1_words", 32'(seqStatus[23:0]), 32'd32);
        check("t1_done", 32'(seqStatus[28]), 32'd1);
        check("t1_strobes", strobe_cnt, 32'd32);
        check("t1_tlast_cnt", tlast_cnt, 32'd1);
        check("t1_left", 32'(exp_word_q.size()), 32'd0);

        // Same frame under random backpressure
        clear_counts();
        rdy_mode = 2;
        push_frame(3);
        csr_write(START);
        check("t2_done_clr", 32'(seqStatus[28]), 32'd0);
        wait_idle("t2", 5000);
        check("t2_words", 32'(seqStatus[23:0]), 32'd32);
        check("t2_done", 32'(seqStatus[28]), 32'd1);
        check("t2_hs", hs_count, 32'd32);
        check("t2_left", 32'(exp_word_q.size()), 32'd0);
        rdy_mode = 1;

        // Start refused while acquiring, then cleared by a valid start
        clear_counts();
        acqStatus = 32'h8000_0001;
        repeat (2) tick();
        csr_write(START);
        repeat (3) tick();
        check("t3_no_strobe", strobe_cnt, 32'd0);
        check("t3_busy", 32'(seqStatus[31]), 32'd0);
        check("t3_rejected", 32'(seqStatus[27]), 32'd1);
        acqStatus = 32'h0000_0001;
        repeat (3) tick();
        push_frame(1);
        csr_write(START);
        check("t3_rej_clr", 32'(seqStatus[27]), 32'd0);
        wait_idle("t3", 2000);
        check("t3_words", 32'(seqStatus[23:0]), 32'd16);

        // Start and abort together in IDLE: abort wins, nothing happens
        csr_write(START | ABORT);
        tick();
        check("t3b_busy", 32'(seqStatus[31]), 32'd0);
        check("t3b_strobes", strobe_cnt, 32'd16);

        // Auto mode: falling acquisition edge starts; rising edge overruns
        clear_counts();
        acqStatus = 32'h8000_0003;
        csr_write(AUTO);
        repeat (2) tick();
        check("t4_auto", 32'(seqStatus[29]), 32'd1);
        check("t4_idle_rise", 32'(seqStatus[31:30]), 32'd0);
        push_frame(3);
        acqStatus = 32'h0000_0003;
        tick();
        check("t4_strobe_early", 32'(seqAddrStrobe), 32'd0);
        tick();
        check("t4_strobe", 32'(seqAddrStrobe), 32'd1);
        n = 0;
        while (hs_count < 9 && n < 1000) begin tick(); n++; end
        check("t4_reach10", 32'(n < 1000), 32'd1);
        acqStatus = 32'h8000_0003;
        tick();
        check("t4_busy", 32'(seqStatus[31]), 32'd0);
        check("t4_overrun", 32'(seqStatus[30]), 32'd1);
        check("t4_tvalid", 32'(m_tvalid), 32'd0);
        check("t4_words", 32'(seqStatus[23:0]), 32'd9);
        check("t4_done", 32'(seqStatus[28]), 32'd0);
        check("t4_tlast_cnt", tlast_cnt, 32'd0);
        flush();
        csr_write(32'd0);
        acqStatus = 32'h0000_0003;
        repeat (4) tick();
        check("t4_no_restart", 32'(seqStatus[31]), 32'd0);

        // Abort during settle of word 5
        clear_counts();
        push_frame(3);
        csr_write(START);
        check("t5_ovr_clr", 32'(seqStatus[30]), 32'd0);
        n = 0;
        while (hs_count < 4 && n < 1000) begin tick(); n++; end
        while (!seqAddrStrobe && n < 1000) begin tick(); n++; end
        check("t5_reach5", 32'(n < 1000), 32'd1);
        repeat (3) tick();
        csr_write(ABORT);
        check("t5_busy", 32'(seqStatus[31]), 32'd0);
        check("t5_tvalid", 32'(m_tvalid), 32'd0);
        check("t5_words", 32'(seqStatus[23:0]), 32'd4);
        check("t5_done", 32'(seqStatus[28]), 32'd0);
        flush();
        repeat (2) tick();

        // Reset while stalled in PUSH, then a one-row frame
        clear_counts();
        rdy_mode = 0;
        push_frame(3);
        csr_write(START);
        n = 0;
        while (!m_tvalid && n < 100) begin tick(); n++; end
        check("t6_push", 32'(m_tvalid), 32'd1);
        repeat (2) tick();
        sysReset = 1'b1;
        tick();
        check("t6_status", seqStatus, 32'd0);
        check("t6_strobe", 32'(seqAddrStrobe), 32'd0);
        check("t6_addr", seqAddrData, 32'd0);
        check("t6_tvalid", 32'(m_tvalid), 32'd0);
        check("t6_tlast", 32'(m_tlast), 32'd0);
        check("t6_tdata", m_tdata, 32'd0);
        sysReset = 1'b0;
        flush();
        clear_counts();
        rdy_mode  = 1;
        acqStatus = 32'h0000_0000;
        tick();
        push_frame(0);
        csr_write(START);
        wait_idle("t6", 1000);
        check("t6_words", 32'(seqStatus[23:0]), 32'd8);
        check("t6_done", 32'(seqStatus[28]), 32'd1);
        check("t6_tlast_cnt", tlast_cnt, 32'd1);
        check("t6_left", 32'(exp_word_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
